// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared pipeline definitions for the execute-stage ALU and its neighbours.
//   - alu_op_e : alusel encodings driven by the decoder
//   - CF/AF/OF : bit positions of the flags inside EFLAGS, used by mw_logic
//                when it merges the registered ALU flags
//   - alu_out_t: bundle of everything the ALU computes for one operation
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int LANE_W = 16;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_OR    = 2'b01,
        ALU_NOT   = 2'b10,
        ALU_PADDW = 2'b11
    } alu_op_e;

    // EFLAGS bit positions
    localparam int CF = 0;
    localparam int AF = 4;
    localparam int OF = 11;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              cf;
        logic              af;
        logic              of;
    } alu_out_t;

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational ALU datapath: 32-bit adder with carry taps at bit 4
// and bit 32, a dual 16-bit lane adder, OR / NOT logic and the output mux.
// Ports:
//   dval   in  [31:0]  destination operand
//   sval   in  [31:0]  source operand (ignored for NOT)
//   alusel in  [1:0]   operation select (alu_op_e)
//   res    out alu_out_t  result plus CF/AF/OF
// ---------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] dval,
    input  logic [DATA_W-1:0] sval,
    input  logic [1:0]        alusel,
    output alu_out_t          res
);

    logic [DATA_W:0]   sum;
    logic              carry_4;
    logic              ovf;
    logic [LANE_W-1:0] lane_lo;
    logic [LANE_W-1:0] lane_hi;

    // One extra bit on the adder gives the carry out of bit 31 directly.
    assign sum = {1'b0, dval} + {1'b0, sval};

    // Carry into bit 4: the sum bit is the XOR of both operand bits and the
    // incoming carry, so XOR-ing the operand bits back out recovers it.
    assign carry_4 = dval[4] ^ sval[4] ^ sum[4];

    // Signed overflow: like-signed operands producing an opposite-signed sum.
    assign ovf = (dval[DATA_W-1] == sval[DATA_W-1]) &&
                 (sum[DATA_W-1] != dval[DATA_W-1]);

    // Independent lanes: the low-lane carry is dropped, never propagated.
    assign lane_lo = dval[LANE_W-1:0]      + sval[LANE_W-1:0];
    assign lane_hi = dval[DATA_W-1:LANE_W] + sval[DATA_W-1:LANE_W];

    always_comb begin
        res = '0;
        unique case (alu_op_e'(alusel))
            ALU_ADD: begin
                res.result = sum[DATA_W-1:0];
                res.cf     = sum[DATA_W];
                res.af     = carry_4;
                res.of     = ovf;
            end
            ALU_OR:    res.result = dval | sval;
            ALU_NOT:   res.result = ~dval;
            ALU_PADDW: res.result = {lane_hi, lane_lo};
            default:   res = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Execute-stage ALU with its MW-stage output latch. The result and flags are
// computed combinationally from the EX operands and captured, together with
// the valid bit, on a rising clock edge when e is high.
// There is no handshake: operands are only guaranteed stable through e, and
// v_out simply qualifies result/flags for the downstream stage.
// Ports:
//   clk    in   rising-edge clock
//   r      in   asynchronous active-low reset, clears all outputs
//   e      in   load enable (driven by !mw_stall); e=0 holds every output
//   v_in   in   EX-stage valid, carried through unused
//   dval   in   [31:0] destination operand
//   sval   in   [31:0] source operand
//   alusel in   [1:0]  operation select
//   result out  [31:0] registered result
//   cf/af/of out registered carry / aux-carry / overflow flags
//   v_out  out  registered valid
// ---------------------------------------------------------------------------
module alu
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              r,
    input  logic              e,
    input  logic              v_in,
    input  logic [DATA_W-1:0] dval,
    input  logic [DATA_W-1:0] sval,
    input  logic [1:0]        alusel,
    output logic [DATA_W-1:0] result,
    output logic              cf,
    output logic              af,
    output logic              of,
    output logic              v_out
);

    alu_out_t core_out;
    alu_out_t out_q;
    logic     v_q;

    alu_core u_core (
        .dval   (dval),
        .sval   (sval),
        .alusel (alusel),
        .res    (core_out)
    );

    // Reset wins over enable, so a reset during a stall clears the latch and
    // it stays clear until the first enabled edge after release.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            out_q <= '0;
            v_q   <= 1'b0;
        end else if (e) begin
            out_q <= core_out;
            v_q   <= v_in;
        end
    end

    assign result = out_q.result;
    assign cf     = out_q.cf;
    assign af     = out_q.af;
    assign of     = out_q.of;
    assign v_out  = v_q;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  typedef struct packed {
    logic [31:0] result;
    logic        cf;
    logic        af;
    logic        of;
    logic        v;
  } obs_t;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        r   = 1'b1;
  logic        e   = 1'b0;
  logic        v_in = 1'b0;
  logic [31:0] dval = '0;
  logic [31:0] sval = '0;
  logic [1:0]  alusel = 2'b00;
  logic [31:0] result;
  logic        cf, af, of, v_out;

  always #5 clk = ~clk;

  alu dut (
    .clk    (clk),
    .r      (r),
    .e      (e),
    .v_in   (v_in),
    .dval   (dval),
    .sval   (sval),
    .alusel (alusel),
    .result (result),
    .cf     (cf),
    .af     (af),
    .of     (of),
    .v_out  (v_out)
  );

  // ---------------- behavioural model ----------------
  function automatic obs_t model(input logic [1:0] op, input logic [31:0] d,
                                 input logic [31:0] s, input logic v);
    obs_t o;
    longint unsigned u;
    longint          sd;
    int              lo, hi;
    o = '0;
    o.v = v;
    case (op)
      2'd0: begin
        u  = longint'(d) + longint'(s);
        sd = longint'($signed(d)) + longint'($signed(s));
        o.result = u % 64'h1_0000_0000;
        o.cf = (u > 64'hFFFF_FFFF);
        o.af = ((d % 16) + (s % 16)) > 15;
        o.of = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      end
      2'd1: o.result = d | s;
      2'd2: o.result = 32'hFFFF_FFFF - d;
      default: begin
        lo = int'((d % 65536) + (s % 65536)) % 65536;
        hi = int'((d / 65536) + (s / 65536)) % 65536;
        o.result = hi * 65536 + lo;
      end
    endcase
    return o;
  endfunction

  obs_t m_q = '0;

  always @(posedge clk or negedge r) begin
    if (!r) m_q <= '0;
    else if (e) m_q <= model(alusel, dval, sval, v_in);
  end

  // ---------------- scoreboard / compare ----------------
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    cmp_en   = 1'b0;
  int    cycle    = 0;
  logic [31:0] exp_q[$];   // literal expectations: result
  obs_t  lit_exp[$];
  string lit_name[$];
  int    lit_req  = 0;
  int    lit_done = 0;

  always @(negedge clk) begin
    obs_t act;
    obs_t le;
    cycle++;
    act = '{result, cf, af, of, v_out};
    if (cmp_en) begin
      n_checks++;
      if (act !== m_q) begin
        n_fail++;
        $display("FAIL model_cmp cycle=%0d got res=%h cf=%b af=%b of=%b v=%b expected res=%h cf=%b af=%b of=%b v=%b",
                 cycle, act.result, act.cf, act.af, act.of, act.v,
                 m_q.result, m_q.cf, m_q.af, m_q.of, m_q.v);
      end
    end
    if (lit_req != lit_done) begin
      le = lit_exp[lit_done];
      n_checks++;
      if (act !== le || result !== exp_q[lit_done]) begin
        n_fail++;
        $display("FAIL %s got res=%h cf=%b af=%b of=%b v=%b expected res=%h cf=%b af=%b of=%b v=%b",
                 lit_name[lit_done], act.result, act.cf, act.af, act.of, act.v,
                 le.result, le.cf, le.af, le.of, le.v);
      end
      lit_done++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic en, input logic v, input logic [1:0] op,
                      input logic [31:0] d, input logic [31:0] s);
    @(posedge clk);
    #1;
    e = en; v_in = v; alusel = op; dval = d; sval = s;
  endtask

  // Queue a literal expectation to be checked at the next falling edge.
  task automatic expect_now(input string name, input logic [31:0] res,
                            input logic c, input logic a, input logic o,
                            input logic v);
    exp_q.push_back(res);
    lit_exp.push_back('{res, c, a, o, v});
    lit_name.push_back(name);
    lit_req++;
  endtask

  // Wait for the capturing edge, then expect.
  task automatic expect_after_edge(input string name, input logic [31:0] res,
                                   input logic c, input logic a, input logic o,
                                   input logic v);
    @(posedge clk);
    #1;
    expect_now(name, res, c, a, o, v);
  endtask

  // ---------------- stimulus ----------------
  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'hFFFF_FFFF;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #2 r = 1'b0;
    #1 expect_now("reset_state", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 r = 1'b1;

    step(1, 1, 2'b00, 32'h0000_0002, 32'h0000_ABCD);
    expect_after_edge("add_basic", 32'h0000_ABCF, 0, 0, 0, 1);
    step(1, 0, 2'b00, 32'hFFFF_FFFF, 32'h0000_0001);
    expect_after_edge("add_carry", 32'h0000_0000, 1, 1, 0, 0);
    step(1, 1, 2'b00, 32'h7FFF_FFFF, 32'h0000_0001);
    expect_after_edge("add_ovf", 32'h8000_0000, 0, 1, 1, 1);
    step(1, 1, 2'b01, 32'hF0F0_0000, 32'h0F0F_1234);
    expect_after_edge("or", 32'hFFFF_1234, 0, 0, 0, 1);
    step(1, 1, 2'b10, 32'h0000_0002, 32'h1234_5678);
    expect_after_edge("not", 32'hFFFF_FFFD, 0, 0, 0, 1);
    step(1, 1, 2'b11, 32'h0001_FFFF, 32'h0001_0001);
    expect_after_edge("paddw_wrap", 32'h0002_0000, 0, 0, 0, 1);
    step(1, 1, 2'b00, 32'h8000_0000, 32'h8000_0000);
    expect_after_edge("add_neg_ovf", 32'h0000_0000, 1, 0, 1, 1);

    // stall: capture then hold for 3 cycles with changing operands
    step(1, 1, 2'b00, 32'h0000_000F, 32'h0000_0001);
    expect_after_edge("stall_capture", 32'h0000_0010, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 2'b10, $urandom(), $urandom());
      expect_after_edge("stall_hold", 32'h0000_0010, 0, 1, 0, 1);
    end

    // reset mid-cycle during stall: clears at once, stays clear until enabled edge
    @(posedge clk);
    #3 r = 1'b0;
    #1 expect_now("reset_async", 32'h0, 0, 0, 0, 0);
    step(1, 1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_after_edge("reset_held", 32'h0, 0, 0, 0, 0);
    step(0, 1, 2'b00, 32'h0000_0001, 32'h0000_0001);
    r = 1'b1;
    expect_after_edge("release_no_en", 32'h0, 0, 0, 0, 0);
    step(1, 1, 2'b00, 32'h0000_0001, 32'h0000_0001);
    expect_after_edge("release_capture", 32'h0000_0002, 0, 0, 0, 1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1),
           2'($urandom_range(0, 3)), rand_operand(), rand_operand());
      if ($urandom_range(0, 60) == 0) begin
        #2 r = 1'b0;
        #3 r = 1'b1;
      end
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    if (lit_req != lit_done) begin
      n_fail++;
      $display("FAIL lit_pending got %0d done expected %0d", lit_done, lit_req);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
